uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter MaxBurst, default 16, max bytes per grant (1..255).
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid_i, input, NumReq, per-requester byte valid.
REQ-006 SHALL have port req_data_i, input, NumReq x 8, per-requester byte.
REQ-007 SHALL have port req_ready_o, output, NumReq, per-requester byte accepted.
REQ-008 SHALL have port tx_valid_o, output, 1, byte pending toward the UART THR write path.
REQ-009 SHALL have port tx_data_o, output, 8, pending byte.
REQ-010 SHALL have port tx_ready_i, input, 1, UART accepts a byte (THR empty / TX FIFO not full).
REQ-011 SHALL have port owner_o, output, $clog2(NumReq), current grant index.
REQ-012 SHALL have port busy_o, output, 1, high when locked or a byte is pending.

Function
REQ-013 SHALL implement an FSM with states ARB_IDLE and ARB_LOCKED.
REQ-014 In ARB_IDLE with any req_valid_i high, SHALL select the first valid index searching round-robin from last_owner+1 (mod NumReq), load owner, clear the burst counter and enter ARB_LOCKED next cycle; all req_ready_o SHALL be 0 in ARB_IDLE.
REQ-015 SHALL drive req_ready_o[i] = (ARB_LOCKED) & (i == owner) & (!tx_valid_o | tx_ready_i); all other bits SHALL be 0.
REQ-016 On owner transfer (valid & ready), SHALL register the byte into tx_data_o and set tx_valid_o the next cycle; latency from accept to tx_valid_o is 1 cycle.
REQ-017 tx_valid_o/tx_data_o SHALL stay stable until tx_ready_i is high; simultaneous drain and new accept in one cycle SHALL sustain one byte per cycle.
REQ-018 Burst counter SHALL be 8 bit, increment per accepted byte, never wrap.
REQ-019 SHALL release (ARB_LOCKED -> ARB_IDLE, last_owner <= owner) on the cycle that the MaxBurst-th byte is accepted.
REQ-020 SHALL release when owner req_valid_i is low for one cycle while ARB_LOCKED.
REQ-021 Release SHALL not drop the pending output byte; arbitration in ARB_IDLE SHALL proceed while tx_valid_o remains set.
REQ-022 A released requester still valid SHALL lose to any other valid requester in the next arbitration; if it is the only one, it SHALL be regranted.
REQ-023 owner_o SHALL show owner in ARB_LOCKED and last_owner in ARB_IDLE.

Reset
REQ-024 On rst_ni low SHALL set state ARB_IDLE, last_owner NumReq-1, owner 0, counter 0, tx_valid_o 0, tx_data_o 8'h00, req_ready_o 0, busy_o 0, owner_o NumReq-1.
REQ-025 Reset mid-burst SHALL discard the pending byte; first grant after reset SHALL go to requester 0 if valid.

Configuration
REQ-026 With UART_TX_ARB_EOL_EN defined, acceptance of byte 8'h0A SHALL release the grant that cycle (in addition to REQ-019/020).
REQ-027 Without UART_TX_ARB_EOL_EN, byte value SHALL have no effect on arbitration.

Structure
REQ-028 uart_pkg SHALL hold state_type_arb enum (ARB_IDLE, ARB_LOCKED) and localparam EolChar = 8'h0A.
REQ-029 Round-robin pick SHALL be a sub-module uart_rr_pick (inputs valid vector, last index; outputs found, index), purely combinational.

Verification
REQ-030 Reset, req0 and req2 valid -> req0 granted, owner_o 0, first tx_valid_o 2 cycles after reset release.
REQ-031 req1 streams 20 bytes, tx_ready_i 1, MaxBurst 16 -> 16 bytes from req1, IDLE bubble, then regrant req1 for remaining 4.
REQ-032 All 4 requesters continuously valid -> grant order 0,1,2,3,0 with 16 bytes each.
REQ-033 tx_ready_i held 0 for 10 cycles with byte 8'h41 pending -> tx_data_o 8'h41 stable, req_ready_o all 0, no byte lost after release.
REQ-034 EOL_EN: req3 sends 8'h48,8'h0A,8'h49 while req0 valid -> req3 released after 8'h0A, req0 granted next; without macro req3 sends all three first.
REQ-035 rst_ni asserted mid-burst with tx_valid_o 1 -> all outputs at REQ-024 values immediately, asynchronously.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } state_type_arb;

  // End-of-line byte that can end a grant early when that feature is built in
  localparam logic [7:0] EolChar = 8'h0A;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of valid_vec
// found by searching upward from last_idx+1, wrapping at NumReq.
module uart_rr_pick #(
  parameter int NumReq = 4,
  parameter int IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid_vec,
  input  logic [IdxW-1:0]   last_idx,
  output logic              found,
  output logic [IdxW-1:0]   idx
);

  logic [IdxW-1:0] cand;

  // Walk candidates from farthest to nearest so the nearest valid one wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = NumReq; k >= 1; k--) begin
      cand = IdxW'((int'(last_idx) + k) % NumReq);
      if (valid_vec[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin byte arbiter in front of a UART transmit holding register.
// One requester holds the grant for up to MaxBurst bytes or until it stops
// presenting data; a one-entry output register feeds the UART.
// Optional build macro UART_TX_ARB_EOL_EN: an accepted 8'h0A also ends the grant.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NumReq   = 4,
  parameter int MaxBurst = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq-1:0][7:0]    req_data_i,
  output logic [NumReq-1:0]         req_ready_o,
  output logic                      tx_valid_o,
  output logic [7:0]                tx_data_o,
  input  logic                      tx_ready_i,
  output logic [$clog2(NumReq)-1:0] owner_o,
  output logic                      busy_o
);

  localparam int              IdxW         = $clog2(NumReq);
  localparam logic [7:0]      BurstLast    = 8'(MaxBurst - 1);
  localparam logic [IdxW-1:0] LastIdxReset = IdxW'(NumReq - 1);

  state_type_arb   state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_owner_q, last_owner_d;
  logic [7:0]      burst_cnt_q, burst_cnt_d;

  logic            slot_free;
  logic            owner_valid;
  logic            accept;
  logic            eol_release;
  logic [7:0]      acc_byte;
  logic            pick_found;
  logic [IdxW-1:0] pick_idx;

  // The output register can take a byte when empty or draining this cycle
  assign slot_free   = !tx_valid_o || tx_ready_i;
  assign owner_valid = req_valid_i[owner_q];
  assign acc_byte    = req_data_i[owner_q];
  assign accept      = (state_q == ARB_LOCKED) && owner_valid && slot_free;

`ifdef UART_TX_ARB_EOL_EN
  assign eol_release = (acc_byte == EolChar);
`else
  assign eol_release = 1'b0;
`endif

  uart_rr_pick #(
    .NumReq(NumReq),
    .IdxW  (IdxW)
  ) u_pick (
    .valid_vec(req_valid_i),
    .last_idx (last_owner_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  // Only the current owner sees ready, and only while the output slot is free
  always_comb begin
    req_ready_o = '0;
    if ((state_q == ARB_LOCKED) && slot_free) begin
      req_ready_o[owner_q] = 1'b1;
    end
  end

  assign owner_o = (state_q == ARB_LOCKED) ? owner_q : last_owner_q;
  assign busy_o  = (state_q == ARB_LOCKED) || tx_valid_o;

  // Grant FSM next-state: pick in idle, count bytes and decide release when locked
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (accept && (burst_cnt_q != 8'hFF)) begin
          burst_cnt_d = burst_cnt_q + 8'd1;
        end
        if (!owner_valid ||
            (accept && ((burst_cnt_q == BurstLast) || eol_release))) begin
          state_d      = ARB_IDLE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Grant FSM state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= LastIdxReset;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // One-entry output register: load on accept, hold until the UART takes it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_valid_o <= 1'b0;
      tx_data_o  <= 8'h00;
    end else if (accept) begin
      tx_valid_o <= 1'b1;
      tx_data_o  <= acc_byte;
    end else if (tx_ready_i) begin
      tx_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed reset/stall checks plus
// scoreboarded rounds whose expected grant and byte order come from a
// transaction-level model of the round-robin burst rules.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NumReq   = 4;
  localparam int MaxBurst = 16;
  localparam int MaxLen   = 48;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NumReq-1:0]      req_valid_i;
  logic [NumReq-1:0][7:0] req_data_i;
  logic [NumReq-1:0]      req_ready_o;
  logic                   tx_valid_o;
  logic [7:0]             tx_data_o;
  logic                   tx_ready_i;
  logic [1:0]             owner_o;
  logic                   busy_o;

  always #5 clk_i = ~clk_i;

  uart_tx_arbiter #(
    .NumReq  (NumReq),
    .MaxBurst(MaxBurst)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_data_i (req_data_i),
    .req_ready_o(req_ready_o),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_ready_i (tx_ready_i),
    .owner_o    (owner_o),
    .busy_o     (busy_o)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] src_mem [NumReq][MaxLen];
  int         src_len [NumReq];
  int         src_pos [NumReq];
  int         exp_owner_q[$];
  logic [7:0] exp_data_q[$];
  int         model_last;
  bit         mon_en = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clearSrc();
    for (int i = 0; i < NumReq; i++) begin
      src_len[i] = 0;
      src_pos[i] = 0;
    end
  endtask

  task automatic fillRandom(input int i, input int len);
    src_len[i] = len;
    for (int j = 0; j < len; j++) src_mem[i][j] = 8'($urandom);
  endtask

  task automatic driveSources();
    for (int i = 0; i < NumReq; i++) begin
      if (src_pos[i] < src_len[i]) begin
        req_valid_i[i] = 1'b1;
        req_data_i[i]  = src_mem[i][src_pos[i]];
      end else begin
        req_valid_i[i] = 1'b0;
        req_data_i[i]  = 8'h00;
      end
    end
  endtask

  // Transaction-level model: who sends which bytes, in which order
  task automatic buildExpected();
    int   pos [NumReq];
    int   last;
    int   pick;
    int   cnt;
    logic [7:0] b;
    for (int i = 0; i < NumReq; i++) pos[i] = 0;
    last = model_last;
    forever begin
      pick = -1;
      for (int k = NumReq; k >= 1; k--) begin
        if (pos[(last + k) % NumReq] < src_len[(last + k) % NumReq])
          pick = (last + k) % NumReq;
      end
      if (pick < 0) break;
      cnt = 0;
      while ((pos[pick] < src_len[pick]) && (cnt < MaxBurst)) begin
        b = src_mem[pick][pos[pick]];
        exp_owner_q.push_back(pick);
        exp_data_q.push_back(b);
        pos[pick]++;
        cnt++;
`ifdef UART_TX_ARB_EOL_EN
        if (b == 8'h0A) break;
`endif
      end
      last = pick;
    end
    model_last = last;
  endtask

  task automatic applyStimulus(input bit rnd_ready);
    int                cyc;
    bit                done;
    bit                drained;
    logic [NumReq-1:0] acc;
    buildExpected();
    for (int i = 0; i < NumReq; i++) src_pos[i] = 0;
    @(posedge clk_i); #1;
    driveSources();
    tx_ready_i = 1'b1;
    cyc  = 0;
    done = 1'b0;
    while (!done && (cyc < 4000)) begin
      @(negedge clk_i);
      acc = req_valid_i & req_ready_o;
      @(posedge clk_i); #1;
      for (int i = 0; i < NumReq; i++)
        if (acc[i] && (src_pos[i] < src_len[i])) src_pos[i]++;
      driveSources();
      tx_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc++;
      drained = 1'b1;
      for (int i = 0; i < NumReq; i++)
        if (src_pos[i] < src_len[i]) drained = 1'b0;
      done = drained && (exp_owner_q.size() == 0) && (exp_data_q.size() == 0)
             && !tx_valid_o;
    end
    checkOutput("round_grants_left", exp_owner_q.size(), 0);
    checkOutput("round_bytes_left", exp_data_q.size(), 0);
    exp_owner_q.delete();
    exp_data_q.delete();
    tx_ready_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  // Monitor: compare every grant and every drained byte against the scoreboard
  initial begin
    logic [NumReq-1:0] mon_acc;
    int                mon_idx;
    int                mon_e;
    bit                prev_stall;
    logic [7:0]        prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk_i);
      if (!mon_en) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checkOutput("hold_valid", tx_valid_o, 1);
          checkOutput("hold_data", tx_data_o, prev_data);
        end
        mon_acc = req_valid_i & req_ready_o;
        if (mon_acc != '0) begin
          checkOutput("grant_onehot", $countones(mon_acc), 1);
          mon_idx = 0;
          for (int i = NumReq - 1; i >= 0; i--) if (mon_acc[i]) mon_idx = i;
          if (exp_owner_q.size() == 0) begin
            checkOutput("grant_unexpected", exp_owner_q.size(), 1);
          end else begin
            mon_e = exp_owner_q.pop_front();
            checkOutput("grant_owner", mon_idx, mon_e);
            checkOutput("owner_o", owner_o, mon_e);
          end
        end
        if (tx_valid_o && tx_ready_i) begin
          if (exp_data_q.size() == 0) begin
            checkOutput("byte_unexpected", exp_data_q.size(), 1);
          end else begin
            checkOutput("tx_data", tx_data_o, exp_data_q.pop_front());
          end
        end
        prev_stall = tx_valid_o && !tx_ready_i;
        prev_data  = tx_data_o;
      end
    end
  end

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    tx_ready_i  = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("rst_tx_valid", tx_valid_o, 0);
    checkOutput("rst_tx_data", tx_data_o, 8'h00);
    checkOutput("rst_req_ready", req_ready_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_owner", owner_o, 3);

    // Stall: byte 8'h41 held while the UART refuses it
    req_valid_i   = 4'b0010;
    req_data_i[1] = 8'h41;
    tx_ready_i    = 1'b0;
    rst_ni        = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("stall_grant", owner_o, 1);
    checkOutput("stall_first_ready", req_ready_o, 4'b0010);
    checkOutput("stall_no_tx_yet", tx_valid_o, 0);
    @(posedge clk_i); #1;
    req_data_i[1] = 8'h42;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      checkOutput("stall_valid", tx_valid_o, 1);
      checkOutput("stall_data", tx_data_o, 8'h41);
      checkOutput("stall_ready", req_ready_o, 0);
    end
    @(posedge clk_i); #1;
    tx_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("unstall_data", tx_data_o, 8'h41);
    checkOutput("unstall_ready", req_ready_o, 4'b0010);
    @(posedge clk_i); #1;
    req_data_i[1] = 8'h43;
    tx_ready_i    = 1'b0;
    @(negedge clk_i);
    checkOutput("next_valid", tx_valid_o, 1);
    checkOutput("next_data", tx_data_o, 8'h42);
    checkOutput("next_busy", busy_o, 1);

    // Asynchronous reset in the middle of a burst with a byte pending
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("async_tx_valid", tx_valid_o, 0);
    checkOutput("async_tx_data", tx_data_o, 8'h00);
    checkOutput("async_req_ready", req_ready_o, 0);
    checkOutput("async_busy", busy_o, 0);
    checkOutput("async_owner", owner_o, 3);

    // First grant after reset goes to requester 0, byte out two cycles later
    req_valid_i   = 4'b0101;
    req_data_i[0] = 8'h5A;
    req_data_i[2] = 8'hA5;
    tx_ready_i    = 1'b1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("first_owner", owner_o, 0);
    checkOutput("first_ready", req_ready_o, 4'b0001);
    checkOutput("first_tx_early", tx_valid_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("first_tx_valid", tx_valid_o, 1);
    checkOutput("first_tx_data", tx_data_o, 8'h5A);

    // Scoreboarded rounds from a clean reset
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    @(negedge clk_i);
    rst_ni     = 1'b1;
    model_last = NumReq - 1;
    mon_en     = 1'b1;

    clearSrc();
    fillRandom(1, 20);
    applyStimulus(1'b1);

    clearSrc();
    for (int i = 0; i < NumReq; i++) fillRandom(i, 40);
    applyStimulus(1'b1);

    clearSrc();
    fillRandom(2, 1);
    applyStimulus(1'b0);

    clearSrc();
    src_len[3]    = 3;
    src_mem[3][0] = 8'h48;
    src_mem[3][1] = 8'h0A;
    src_mem[3][2] = 8'h49;
    src_len[0]    = 2;
    src_mem[0][0] = 8'h10;
    src_mem[0][1] = 8'h11;
    applyStimulus(1'b0);

    for (int r = 0; r < 6; r++) begin
      clearSrc();
      for (int i = 0; i < NumReq; i++) fillRandom(i, $urandom_range(0, 40));
      applyStimulus(1'b1);
    end

    mon_en = 1'b0;
    @(negedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
